// File: rtl/cache_arbiter.sv
// Line-level arbiter between the I-cache and D-cache miss handlers and the
// single physical-memory port. One requester is served at a time; its
// command is registered toward memory and held until pmem_resp, and the
// response is routed back only to the granted side. Contention is resolved
// round-robin so neither the fetch stage nor the MEM stage can starve.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer outstanding; arbitrate between req_i and req_d
// SERVE_I | I-cache line read outstanding on the memory port
// SERVE_D | D-cache line read or writeback outstanding on the memory port

module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,

  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                  state_q,        state_d;
  logic                    last_grant_q,   last_grant_d;
  logic                    pmem_read_q,    pmem_read_d;
  logic                    pmem_write_q,   pmem_write_d;
  logic [ADDR_WIDTH-1:0]   pmem_address_q, pmem_address_d;
  logic [LINE_WIDTH-1:0]   pmem_wdata_q,   pmem_wdata_d;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  assign req_i = icache_read;
  assign req_d = dcache_read | dcache_write;

  // Round-robin pick: on contention the side that did not win last time goes.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      grant_d = (last_grant_q == GRANT_I);
      grant_i = (last_grant_q == GRANT_D);
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

  // Next-state and command capture; commands only change on grant or response.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d        = SERVE_I;
          last_grant_d   = GRANT_I;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = icache_address;
          pmem_wdata_d   = '0;
        end else if (grant_d) begin
          state_d        = SERVE_D;
          last_grant_d   = GRANT_D;
          // a writeback wins over a read if the D-cache ever asserts both
          pmem_read_d    = dcache_read & ~dcache_write;
          pmem_write_d   = dcache_write;
          pmem_address_d = dcache_address;
          pmem_wdata_d   = dcache_wdata;
        end
      end

      SERVE_I, SERVE_D: begin
        // requester inputs are deliberately ignored here; only memory ends it
        if (pmem_resp) begin
          state_d      = IDLE;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end
      end

      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and command registers; reset abandons any outstanding transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  // Response routing is combinational so the cache sees it in the same cycle.
  always_comb begin
    icache_resp  = (state_q == SERVE_I) && pmem_resp;
    dcache_resp  = (state_q == SERVE_D) && pmem_resp;
    icache_rdata = icache_resp ? pmem_rdata : '0;
    dcache_rdata = dcache_resp ? pmem_rdata : '0;
  end

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read && pmem_write));

  a_dcache_protocol: assert property (@(posedge clk) disable iff (!rst)
    !(dcache_read && dcache_write));

  a_iresp_in_serve_i: assert property (@(posedge clk) disable iff (!rst)
    icache_resp |-> (state_q == SERVE_I));

  a_dresp_in_serve_d: assert property (@(posedge clk) disable iff (!rst)
    dcache_resp |-> (state_q == SERVE_D));

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter. A transaction-level reference model
// predicts which side is granted and what command reaches memory; a memory
// model checks commands against that prediction and pushes the response it
// returns; a monitor checks every cycle that responses reach the right cache.

module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          icache_read = 1'b0;
  logic [AW-1:0] icache_address = '0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [AW-1:0] dcache_address = '0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // side encoding: 0 = I-cache, 1 = D-cache
  typedef struct packed {
    logic          side;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic          side;
    logic [LW-1:0] data;
  } rsp_t;

  cmd_t exp_cmd_q[$];
  rsp_t exp_rsp_q[$];
  logic grant_log[$];
  int   gap_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus knobs
  int   i_prob = 0;
  int   d_prob = 0;
  logic use_fixed = 1'b0;
  logic drv_clear = 1'b0;
  logic spurious_en = 1'b0;
  int   mem_lat = -1;

  int   i_resp_cnt = 0;
  int   d_resp_cnt = 0;
  logic m_busy = 1'b0;
  logic mem_busy = 1'b0;

  localparam logic [LW-1:0] LINE_AA = {32{8'hAA}};
  localparam logic [LW-1:0] LINE_WB = {8{32'h1234_5678}};

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Requesters: raise at random, hold until their response, drop right after.
  initial begin
    int i_ack = 0;
    int d_ack = 0;
    logic wr;
    forever begin
      @(posedge clk); #1;
      if (drv_clear) begin
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        i_ack = i_resp_cnt; d_ack = d_resp_cnt;
      end else begin
        if (icache_read) begin
          if (i_resp_cnt != i_ack) begin icache_read = 1'b0; i_ack = i_resp_cnt; end
        end else if (int'($urandom_range(0, 99)) < i_prob) begin
          icache_read    = 1'b1;
          icache_address = use_fixed ? 32'h0000_0040 : ($urandom & 32'hFFFF_FFE0);
        end
        if (dcache_read || dcache_write) begin
          if (d_resp_cnt != d_ack) begin
            dcache_read = 1'b0; dcache_write = 1'b0; d_ack = d_resp_cnt;
          end
        end else if (int'($urandom_range(0, 99)) < d_prob) begin
          wr             = use_fixed ? 1'b1 : 1'($urandom_range(0, 1));
          dcache_write   = wr;
          dcache_read    = ~wr;
          dcache_address = use_fixed ? 32'h0000_1000 : ($urandom & 32'hFFFF_FFE0);
          dcache_wdata   = use_fixed ? LINE_WB : rand_line();
        end
      end
    end
  end

  // Reference model: one transfer at a time, alternate sides on contention,
  // re-arbitrate only at the edge after the edge that saw the response.
  initial begin
    logic m_last = 1'b0;
    logic ri, rd, side;
    cmd_t c;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_busy = 1'b0; m_last = 1'b0; exp_cmd_q.delete();
      end else if (m_busy) begin
        if (pmem_resp) m_busy = 1'b0;
      end else begin
        ri = icache_read;
        rd = dcache_read | dcache_write;
        if (ri || rd) begin
          side = (ri && rd) ? ~m_last : rd;
          c.side = side;
          if (!side) begin
            c.rd = 1'b1; c.wr = 1'b0; c.addr = icache_address; c.wdata = '0;
          end else begin
            c.wr = dcache_write; c.rd = dcache_read & ~dcache_write;
            c.addr = dcache_address; c.wdata = dcache_wdata;
          end
          exp_cmd_q.push_back(c);
          m_busy = 1'b1;
          m_last = side;
        end
      end
    end
  end

  // Memory model: accept commands, check them, answer after a latency.
  initial begin
    int iter = 0;
    int last_resp_iter = 0;
    int cnt = 0;
    logic cur_side = 1'b0;
    logic [AW+LW+1:0] hold = '0;
    cmd_t c;
    rsp_t r;
    forever begin
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (!rst) begin
        mem_busy = 1'b0; exp_rsp_q.delete(); last_resp_iter = iter;
      end else if (!mem_busy && (pmem_read || pmem_write)) begin
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", {pmem_read, pmem_write, pmem_address}, '0);
        end else begin
          c = exp_cmd_q.pop_front();
          check("cmd", {pmem_read, pmem_write, pmem_address, pmem_wdata},
                {c.rd, c.wr, c.addr, c.wdata});
          cur_side = c.side;
          grant_log.push_back(c.side);
          gap_log.push_back(iter - last_resp_iter);
          hold = {pmem_read, pmem_write, pmem_address, pmem_wdata};
          mem_busy = 1'b1;
          cnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 5));
        end
      end else if (mem_busy) begin
        check("cmd_hold", {pmem_read, pmem_write, pmem_address, pmem_wdata}, hold);
        if (cnt == 0) begin
          pmem_resp = 1'b1;
          if (use_fixed) pmem_rdata = LINE_AA;
          r.side = cur_side; r.data = pmem_rdata;
          exp_rsp_q.push_back(r);
          mem_busy = 1'b0;
          last_resp_iter = iter;
        end else begin
          cnt--;
        end
      end else if (spurious_en && $urandom_range(0, 7) == 0) begin
        pmem_resp = 1'b1;
      end
      iter++;
    end
  end

  // Monitor: every cycle, a response exactly when one is due, to the right side.
  initial begin
    rsp_t r;
    logic have;
    forever begin
      @(negedge clk);
      if (rst) begin
        have = (exp_rsp_q.size() > 0);
        check("resp_present", 512'(icache_resp | dcache_resp), 512'(have));
        if (have) begin
          r = exp_rsp_q.pop_front();
          check("resp_side", {icache_resp, dcache_resp}, r.side ? 2'b01 : 2'b10);
          if (r.side) begin
            check("d_rdata", dcache_rdata, r.data);
            check("i_rdata_quiet", icache_rdata, '0);
          end else begin
            check("i_rdata", icache_rdata, r.data);
            check("d_rdata_quiet", dcache_rdata, '0);
          end
        end else begin
          check("rdata_quiet", {icache_rdata, dcache_rdata}, '0);
        end
        if (icache_resp) i_resp_cnt++;
        if (dcache_resp) d_resp_cnt++;
      end
    end
  end

  task automatic wait_grants(input int target, input int budget);
    int k = 0;
    while (grant_log.size() < target && k < budget) begin
      @(negedge clk); k++;
    end
    check("wait_grants", 512'(grant_log.size() >= target), 512'(1));
  endtask

  task automatic drain(input int budget);
    int k = 0;
    i_prob = 0; d_prob = 0;
    while ((icache_read || dcache_read || dcache_write || m_busy || mem_busy ||
            exp_cmd_q.size() != 0 || exp_rsp_q.size() != 0) && k < budget) begin
      @(negedge clk); k++;
    end
    check("drain", 512'(k < budget), 512'(1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int k;

    // Both sides request while reset is held; D must win first.
    use_fixed = 1'b1; mem_lat = 4; i_prob = 100; d_prob = 100;
    repeat (3) @(negedge clk);
    check("reset_cmd", {pmem_read, pmem_write, pmem_address, pmem_wdata}, '0);
    check("reset_resp", {icache_resp, dcache_resp, icache_rdata, dcache_rdata}, '0);
    rst = 1'b1;
    wait_grants(4, 200);
    if (grant_log.size() >= 4) begin
      check("first_grant_d", 512'(grant_log[0]), 512'(1));
      check("order_1", 512'(grant_log[1]), 512'(0));
      check("order_2", 512'(grant_log[2]), 512'(1));
      check("order_3", 512'(grant_log[3]), 512'(0));
      check("first_latency", 512'(gap_log[0]), 512'(1));
      for (int g = 1; g < 4; g++) check("bubble_gap", 512'(gap_log[g]), 512'(2));
    end
    drain(200);

    // Random traffic with stray pmem_resp pulses while idle.
    use_fixed = 1'b0; mem_lat = -1; spurious_en = 1'b1;
    i_prob = 30; d_prob = 30;
    repeat (3000) @(negedge clk);
    drain(400);
    spurious_en = 1'b0;

    // Reset in the middle of a D writeback.
    use_fixed = 1'b1; mem_lat = 6; d_prob = 100;
    k = 0;
    while (!pmem_write && k < 50) begin @(negedge clk); k++; end
    check("wb_started", 512'(pmem_write), 512'(1));
    d_prob = 0;
    @(negedge clk); #2;
    rst = 1'b0; drv_clear = 1'b1;
    #1;
    check("midreset_cmd", {pmem_read, pmem_write, pmem_address, pmem_wdata}, '0);
    check("midreset_resp", {icache_resp, dcache_resp}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1; drv_clear = 1'b0;
    use_fixed = 1'b0; mem_lat = -1;

    // I alone after reset, then simultaneous contention favours D.
    base = grant_log.size();
    i_prob = 100;
    wait_grants(base + 1, 50);
    if (grant_log.size() > base) check("post_reset_i", 512'(grant_log[base]), 512'(0));
    drain(100);
    base = grant_log.size();
    i_prob = 100; d_prob = 100;
    wait_grants(base + 2, 100);
    if (grant_log.size() > base + 1) begin
      check("rr_after_i_d", 512'(grant_log[base]), 512'(1));
      check("rr_after_i_i", 512'(grant_log[base + 1]), 512'(0));
    end
    drain(100);

    check("queues_empty", 512'(exp_cmd_q.size() + exp_rsp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Line-level arbiter between the instruction cache and the data cache, which are the miss handlers behind the datapath's inst_* and data_* ports, and the single physical-memory (cacheline adaptor) port.
- Grants one requester at a time and registers its command toward memory. It routes the memory response back only to the granted side.
- Round-robin on contention, so that neither the fetch stage nor the MEM stage can be starved.

Parameters:
ADDR_WIDTH, 32, byte address width of all line requests
LINE_WIDTH, 256, cacheline width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
icache_read  in  1  I-cache line read request; held until icache_resp
icache_address  in  ADDR_WIDTH  I-cache line address (line-aligned)
icache_rdata  out  LINE_WIDTH  line returned to I-cache
icache_resp  out  1  one-cycle completion pulse to I-cache
dcache_read  in  1  D-cache line read request
dcache_write  in  1  D-cache line writeback request
dcache_address  in  ADDR_WIDTH  D-cache line address
dcache_wdata  in  LINE_WIDTH  writeback line
dcache_rdata  out  LINE_WIDTH  line returned to D-cache
dcache_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  memory read command (registered)
pmem_write  out  1  memory write command (registered)
pmem_address  out  ADDR_WIDTH  memory address (registered)
pmem_wdata  out  LINE_WIDTH  memory write line (registered)
pmem_rdata  in  LINE_WIDTH  memory read line, valid with pmem_resp
pmem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. The last_grant flag (I or D) is also registered.
- Reset (rst=0, async): state=IDLE, last_grant=I, and pmem_read/pmem_write/pmem_address/pmem_wdata=0. icache_resp=dcache_resp=0, and both rdata outputs=0.
- Reset mid-transaction: the command drops immediately and the outstanding transfer is abandoned. The memory side tolerates this.
- IDLE arbitration:
  - req_i = icache_read. req_d = dcache_read | dcache_write.
  - Only req_i -> SERVE_I.
  - Only req_d -> SERVE_D.
  - Both -> grant the side not equal to last_grant. After reset this is D first.
  - Neither -> stay in IDLE.
- On grant (the IDLE->SERVE_x edge), capture into the pmem registers:
  - I: read=1, write=0, address=icache_address, wdata=0.
  - D: read=dcache_read, write=dcache_write, address=dcache_address, wdata=dcache_wdata.
  - last_grant <= granted side.
- Latency: a request first sampled in IDLE in cycle N gives pmem_read/pmem_write high from cycle N+1.
- If dcache_read and dcache_write are both high, write wins (pmem_write=1, pmem_read=0). This is a protocol violation and is flagged by an assertion.
- SERVE_x:
  - The pmem command registers hold constant until pmem_resp.
  - Requester inputs are not re-sampled, so a requester dropping its request mid-transfer has no effect.
- Response in SERVE_x with pmem_resp=1:
  - x_resp=1 combinationally in the same cycle. x_rdata=pmem_rdata in that cycle; otherwise x_rdata=0.
  - The other side's resp stays 0.
  - Next edge: state->IDLE and pmem_read/pmem_write<=0.
- Mandatory IDLE bubble: one IDLE cycle always follows each response, so the granted cache has deasserted its request before re-arbitration. Back-to-back transfers therefore have a 1-cycle gap between response and the next command.
- pmem_resp while in IDLE is ignored and produces no resp pulse to either side.
- Simultaneous events:
  - A new request arriving in the same cycle as pmem_resp for the other side is granted in the following IDLE cycle.
  - If the just-served side re-requests in that IDLE cycle while the other side is also requesting, the other side wins by round-robin.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D.
- Assertions: pmem_read and pmem_write are never both 1; x_resp is never 1 outside SERVE_x.

Test Plan:
- Reset with both requests high, release rst -> first grant D; pmem_write/pmem_read=0 during reset; D command appears 1 cycle after the first IDLE sample.
- I-only read of 0x0000_0040; memory returns line 0xAA..AA after 5 cycles -> pmem_read=1 with address 0x40 held for 5 cycles; icache_resp one-cycle pulse with rdata 0xAA..AA; dcache_resp=0 throughout.
- D writeback to 0x0000_1000 with wdata 0x1234..5678 -> pmem_write=1, pmem_address=0x1000, wdata stable until pmem_resp; dcache_resp pulse; icache_resp=0.
- Both sides requesting continuously for 4 transfers -> grant order D, I, D, I; exactly one IDLE cycle between each pmem_resp and the next command.
- I granted; D request rises in the pmem_resp cycle; D served next -> no glitch on pmem_address during SERVE_I; D gets the next grant; I-cache rdata is 0 outside its resp cycle.
- Assert rst low mid-SERVE_D -> pmem_write drops immediately, no resp pulses; after release, an I request is served normally and last_grant=I gives D priority on the next contention.
